lcd_spi_write: RTL and testbench

- Serial write engine for the LCD panel. It sits downstream of the LCD command/picture sequencers and upstream of the panel pins.
- It accepts one 9-bit word per request: bit 8 is the D/C flag (0 = command, 1 = pixel or parameter data) and bits 7:0 are the payload byte.
- It shifts the byte out on a 4-wire SPI bus (mode 0, MSB first) and returns a single-cycle wr_done pulse when the transfer is finished.
- It is the responder side of the en_write/data/wr_done handshake that the sequencers drive.

---
 rtl/lcd_spi_write_pkg.sv | 34 +++
 rtl/lcd_spi_write_if.sv | 14 +
 rtl/lcd_spi_write.sv | 123 ++++++++++++
 tb/tb_lcd_spi_write.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_spi_write_pkg.sv
// Shared LCD definitions: write-engine state encoding, D/C flag values,
// and the colour/command constants the sequencers already use.
package lcd_pkg;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_SETUP = 5'b00010,
    ST_SHIFT = 5'b00100,
    ST_DONE  = 5'b01000,
    ST_GUARD = 5'b10000
  } lcd_state_e;

  localparam int unsigned WORD_W = 9;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam logic [WORD_W-1:0] CMD_RAMWR = 9'h02C;

  // RGB565 colours
  localparam logic [15:0] COLOR_WHITE   = 16'hFFFF;
  localparam logic [15:0] COLOR_BLACK   = 16'h0000;
  localparam logic [15:0] COLOR_RED     = 16'hF800;
  localparam logic [15:0] COLOR_GREEN   = 16'h07E0;
  localparam logic [15:0] COLOR_BLUE    = 16'h001F;
  localparam logic [15:0] COLOR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] COLOR_CYAN    = 16'h07FF;
  localparam logic [15:0] COLOR_MAGENTA = 16'hF81F;

  function automatic logic [WORD_W-1:0] lcd_word(input logic dc, input logic [7:0] payload);
    return {dc, payload};
  endfunction

endpackage

// File: rtl/lcd_spi_write_if.sv
// Request/completion handshake between the LCD sequencers (master) and the
// SPI write engine (slave).
interface lcd_spi_write_if;
  import lcd_pkg::*;

  logic              en_write;
  logic [WORD_W-1:0] data;
  logic              wr_done;
  logic              busy;

  modport master (output en_write, output data, input wr_done, input busy);
  modport slave  (input en_write, input data, output wr_done, output busy);

endinterface

// File: rtl/lcd_spi_write.sv
// SPI write engine: shifts one {dc, byte} word out MSB first (mode 0) and
// pulses wr_done on completion, then ignores requests for a short guard window.
module lcd_spi_write
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned CS_SETUP     = 1,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  lcd_spi_write_if.slave   host,
  output logic             lcd_cs_n,
  output logic             lcd_sclk,
  output logic             lcd_mosi,
  output logic             lcd_dc
);

  localparam int unsigned PW = $clog2(CLK_DIV + 1);

  lcd_state_e        state, state_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic [PW-1:0]     phase_cnt, phase_cnt_nxt;
  logic              sclk_hi, sclk_hi_nxt;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic [3:0]        wait_cnt, wait_cnt_nxt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      phase_cnt <= '0;
      sclk_hi   <= 1'b0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      phase_cnt <= phase_cnt_nxt;
      sclk_hi   <= sclk_hi_nxt;
      bit_cnt   <= bit_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    phase_cnt_nxt = phase_cnt;
    sclk_hi_nxt   = sclk_hi;
    bit_cnt_nxt   = bit_cnt;
    wait_cnt_nxt  = wait_cnt;

    unique case (state)
      ST_IDLE: begin
        if (host.en_write) begin
          state_nxt    = ST_SETUP;
          shreg_nxt    = host.data;
          wait_cnt_nxt = '0;
        end
      end

      ST_SETUP: begin
        if (wait_cnt == 4'(CS_SETUP - 1)) begin
          state_nxt     = ST_SHIFT;
          phase_cnt_nxt = '0;
          sclk_hi_nxt   = 1'b0;
          bit_cnt_nxt   = 3'd7;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end

      ST_SHIFT: begin
        if (phase_cnt == PW'(CLK_DIV - 1)) begin
          phase_cnt_nxt = '0;
          if (!sclk_hi) begin
            sclk_hi_nxt = 1'b1;
          end else begin
            sclk_hi_nxt = 1'b0;
            if (bit_cnt == 3'd0) begin
              state_nxt = ST_DONE;
            end else begin
              // Next bit lands on shreg[7] exactly as the new low phase starts;
              // shreg[8] keeps the D/C flag for the whole transfer.
              bit_cnt_nxt = bit_cnt - 3'd1;
              shreg_nxt   = {shreg[8], shreg[6:0], 1'b0};
            end
          end
        end else begin
          phase_cnt_nxt = phase_cnt + 1'b1;
        end
      end

      ST_DONE: begin
        wait_cnt_nxt = '0;
        state_nxt    = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
      end

      ST_GUARD: begin
        if (wait_cnt == 4'(GUARD_CYCLES - 1)) begin
          state_nxt = ST_IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pins are decoded from registered state, so reset releases CS and SCLK at once.
  always_comb begin
    lcd_cs_n = !((state == ST_SETUP) || (state == ST_SHIFT));
    lcd_sclk = (state == ST_SHIFT) && sclk_hi;
    lcd_mosi = shreg[7];
    lcd_dc   = shreg[8];
  end

  assign host.wr_done = (state == ST_DONE);
  assign host.busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_lcd_spi_write.sv
// Bench for lcd_spi_write: default and fast-parameter instances checked every
// cycle against a timing model derived from acceptance edges.
module tb_lcd_spi_write;
  import lcd_pkg::*;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  lcd_spi_write_if if_a ();
  lcd_spi_write_if if_b ();

  logic cs_a, sclk_a, mosi_a, dc_a;
  logic cs_b, sclk_b, mosi_b, dc_b;

  lcd_spi_write #(.CLK_DIV(2), .CS_SETUP(1), .GUARD_CYCLES(2)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .host(if_a),
    .lcd_cs_n(cs_a), .lcd_sclk(sclk_a), .lcd_mosi(mosi_a), .lcd_dc(dc_a)
  );

  lcd_spi_write #(.CLK_DIV(1), .CS_SETUP(1), .GUARD_CYCLES(0)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .host(if_b),
    .lcd_cs_n(cs_b), .lcd_sclk(sclk_b), .lcd_mosi(mosi_b), .lcd_dc(dc_b)
  );

  int p_div[2]   = '{2, 1};
  int p_cs[2]    = '{1, 1};
  int p_guard[2] = '{2, 0};

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // Reference model state: last accepted word per instance
  bit         have[2];
  int         acc[2];
  int         next_free[2];
  logic [8:0] word[2];
  int         rises[2];
  logic [7:0] cap[2];
  logic [7:0] done_byte[2];
  int         n_done[2];
  int         last_done[2];
  bit         prev_sclk[2];
  bit         alt_mode = 1'b0;

  typedef struct {
    logic [8:0] data;
    logic       exp_dc;
    logic [7:0] exp_bits;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic sample(input int i);
    logic o_cs, o_sclk, o_mosi, o_dc, o_done, o_busy;
    int e, k, span, idx;
    bit cs_exp, sclk_exp, done_exp, busy_exp;
    string nm;
    nm = (i == 0) ? "a" : "b";
    if (i == 0) begin
      o_cs = cs_a; o_sclk = sclk_a; o_mosi = mosi_a; o_dc = dc_a;
      o_done = if_a.wr_done; o_busy = if_a.busy;
    end else begin
      o_cs = cs_b; o_sclk = sclk_b; o_mosi = mosi_b; o_dc = dc_b;
      o_done = if_b.wr_done; o_busy = if_b.busy;
    end
    e    = edge_n;
    span = 16 * p_div[i];
    k    = e - acc[i] - p_cs[i];
    cs_exp   = have[i] && e >= acc[i] && e < acc[i] + p_cs[i] + span;
    sclk_exp = have[i] && k >= 0 && k < span && ((k / p_div[i]) % 2 == 1);
    done_exp = have[i] && e == acc[i] + p_cs[i] + span;
    busy_exp = have[i] && e >= acc[i] && e <= acc[i] + p_cs[i] + span + p_guard[i];
    check({nm, "_cs_n"}, int'(o_cs), int'(!cs_exp));
    check({nm, "_sclk"}, int'(o_sclk), int'(sclk_exp));
    check({nm, "_wr_done"}, int'(o_done), int'(done_exp));
    check({nm, "_busy"}, int'(o_busy), int'(busy_exp));
    if (o_sclk && !prev_sclk[i]) begin
      rises[i]++;
      cap[i] = {cap[i][6:0], o_mosi};
      if (have[i] && k >= 0 && k < span) begin
        idx = 7 - k / (2 * p_div[i]);
        check({nm, "_mosi"}, int'(o_mosi), int'(word[i][idx]));
      end
    end
    if (done_exp) begin
      check({nm, "_rise_count"}, rises[i], 8);
      check({nm, "_dc"}, int'(o_dc), int'(word[i][8]));
      done_byte[i] = cap[i];
    end
    if (o_done) begin
      n_done[i]++;
      last_done[i] = e;
    end
    prev_sclk[i] = o_sclk;
  endtask

  task automatic tick();
    logic       rst_s;
    logic       en_s[2];
    logic [8:0] d_s[2];
    rst_s = sys_rst;
    en_s[0] = if_a.en_write; d_s[0] = if_a.data;
    en_s[1] = if_b.en_write; d_s[1] = if_b.data;
    @(posedge sys_clk);
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      if (rst_s) begin
        have[i] = 1'b0;
        next_free[i] = edge_n + 1;
      end else if (en_s[i] && edge_n >= next_free[i]) begin
        have[i] = 1'b1;
        acc[i] = edge_n;
        word[i] = d_s[i];
        rises[i] = 0;
        cap[i] = '0;
        next_free[i] = edge_n + 2 + p_cs[i] + 16 * p_div[i] + p_guard[i];
      end
    end
    #1;
    for (int i = 0; i < 2; i++) sample(i);
    if (alt_mode && have[0] && acc[0] == edge_n)
      if_a.data = (if_a.data == 9'h1F8) ? 9'h100 : 9'h1F8;
  endtask

  task automatic wait_done(input int i, input int budget);
    int start = n_done[i];
    int n = 0;
    while (n_done[i] == start && n < budget) begin
      tick();
      n++;
    end
    if (n_done[i] == start) check("wr_done_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (have[i] && edge_n < next_free[i] && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    vec_t vecs[5];
    int a0, d1, d2;
    logic [7:0] b1, b2;
    int start;

    vecs[0] = '{CMD_RAMWR, DC_CMD, 8'b0010_1100};
    vecs[1] = '{9'h1A5, DC_DATA, 8'b1010_0101};
    vecs[2] = '{9'h1F8, DC_DATA, 8'b1111_1000};
    vecs[3] = '{9'h0FF, DC_CMD, 8'b1111_1111};
    vecs[4] = '{lcd_word(DC_DATA, 8'h5A), DC_DATA, 8'b0101_1010};

    if_a.en_write = 1'b0; if_a.data = '0;
    if_b.en_write = 1'b0; if_b.data = '0;

    sys_rst = 1'b1;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();
    check("a_rst_mosi", int'(mosi_a), 0);
    check("a_rst_dc", int'(dc_a), 0);
    check("b_rst_mosi", int'(mosi_b), 0);
    check("b_rst_dc", int'(dc_b), 0);
    repeat (10) tick();

    // Single pulses; data is scrambled right after acceptance
    foreach (vecs[v]) begin
      if_a.data = vecs[v].data;
      if_a.en_write = 1'b1;
      tick();
      if_a.en_write = 1'b0;
      if_a.data = 9'($urandom);
      wait_done(0, 100);
      check("a_vec_byte", int'(done_byte[0]), int'(vecs[v].exp_bits));
      check("a_vec_dc", int'(dc_a), int'(vecs[v].exp_dc));
      check("a_vec_latency", last_done[0] - acc[0], 33);
      wait_idle(0);
      repeat (2) tick();
    end

    // Held request: one transfer only
    start = n_done[0];
    if_a.data = CMD_RAMWR;
    if_a.en_write = 1'b1;
    wait_done(0, 100);
    repeat (2) tick();
    if_a.en_write = 1'b0;
    repeat (40) tick();
    check("a_held_done_count", n_done[0] - start, 1);

    // Back-to-back with alternating data
    if_a.data = 9'h1F8;
    if_a.en_write = 1'b1;
    alt_mode = 1'b1;
    wait_done(0, 100);
    b1 = done_byte[0]; d1 = last_done[0];
    wait_done(0, 100);
    b2 = done_byte[0]; d2 = last_done[0];
    if_a.en_write = 1'b0;
    alt_mode = 1'b0;
    check("a_b2b_byte0", int'(b1), 'hF8);
    check("a_b2b_byte1", int'(b2), 'h00);
    check("a_b2b_period", d2 - d1, 37);
    wait_idle(0);
    tick();

    // Reset during bit 4
    if_a.data = 9'h1A5;
    if_a.en_write = 1'b1;
    tick();
    if_a.en_write = 1'b0;
    a0 = acc[0];
    while (edge_n < a0 + 14 && edge_n < a0 + 40) tick();
    sys_rst = 1'b1;
    tick();
    check("a_abort_cs_n", int'(cs_a), 1);
    check("a_abort_sclk", int'(sclk_a), 0);
    sys_rst = 1'b0;
    start = n_done[0];
    repeat (40) tick();
    check("a_abort_no_done", n_done[0] - start, 0);
    if_a.data = 9'h0A5;
    if_a.en_write = 1'b1;
    tick();
    if_a.en_write = 1'b0;
    wait_done(0, 100);
    check("a_after_abort_byte", int'(done_byte[0]), 'hA5);
    check("a_after_abort_dc", int'(dc_a), 0);
    wait_idle(0);

    // Fast instance: held request re-accepted right after DONE
    if_b.data = 9'h1C3;
    if_b.en_write = 1'b1;
    wait_done(1, 60);
    a0 = acc[1]; d1 = last_done[1];
    check("b_latency", d1 - a0, 17);
    wait_done(1, 60);
    if_b.en_write = 1'b0;
    check("b_reaccept", acc[1] - a0, 19);
    check("b_period", last_done[1] - d1, 19);
    check("b_byte", int'(done_byte[1]), 'hC3);
    wait_idle(1);

    // Random traffic on both instances
    for (int n = 0; n < 1200; n++) begin
      if_a.en_write = ($urandom_range(0, 3) == 0);
      if_a.data = 9'($urandom);
      if_b.en_write = ($urandom_range(0, 2) == 0);
      if_b.data = 9'($urandom);
      tick();
    end
    if_a.en_write = 1'b0;
    if_b.en_write = 1'b0;
    repeat (60) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
